seg7_counter_display: RTL and testbench

Display-side reader for the key-driven counters on the LED board. It accepts a packed hex value from a counter, such as the left and right nibble counters concatenated. It holds a double-buffered copy of that value and drives the dynamic seven-segment display by time-multiplexing one digit at a time. A blanking gap between digits suppresses ghosting. New values take effect only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg7_display_pkg.sv | 15 +
 rtl/seg7_digit_mux.sv | 24 ++
 rtl/seg7_counter_display.sv | 80 ++++++++
 tb/tb_seg7_counter_display.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_display_pkg.sv
// seg7_display_pkg: shared scan states and the hex seven-segment font (a..g, bit 6 = a).
package seg7_display_pkg;

    typedef enum logic {BLANK, DRIVE} state_t;

    localparam logic [6:0] seg_font [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return seg_font[nibble];
    endfunction

endpackage

// File: rtl/seg7_digit_mux.sv
// seg7_digit_mux: picks the nibble and decimal point for one digit and renders its segments.
module seg7_digit_mux
    import seg7_display_pkg::*;
#(
    parameter int w_digit = 8,
    parameter int iw      = 3
) (
    input  logic [4*w_digit-1:0] i_value,
    input  logic [w_digit-1:0]   i_dp_mask,
    input  logic [iw-1:0]        i_idx,
    input  logic                 i_lz_blank,
    output logic [7:0]           o_seg
);
    logic [3:0] w_nibble;
    logic       w_lz;

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_nibble = i_value[4*i_idx +: 4];
        w_lz     = i_lz_blank && i_idx != '0 && (i_value >> {i_idx, 2'b00}) == '0;
        o_seg    = {w_lz ? 7'h00 : hex_to_seg(w_nibble), i_dp_mask[i_idx]};
    end

endmodule

// File: rtl/seg7_counter_display.sv
// seg7_counter_display: double-buffered, time-multiplexed seven-segment driver.
// New values commit only at frame boundaries; each digit slot opens with a blanking gap.
module seg7_counter_display
    import seg7_display_pkg::*;
#(
    parameter int clk_mhz      = 50,
    parameter int w_digit      = 8,
    parameter int w_value      = 4 * w_digit,
    parameter int scan_period  = clk_mhz * 1000,
    parameter int blank_cycles = clk_mhz
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_value-1:0] value,
    input  logic               value_valid,
    input  logic               lz_blank,
    input  logic [w_digit-1:0] dp_mask,
    output logic [7:0]         abcdefgh,
    output logic [w_digit-1:0] digit,
    output logic               frame_done
);
    localparam int IW = w_digit > 1 ? $clog2(w_digit) : 1;
    localparam int CW = scan_period > 1 ? $clog2(scan_period) : 1;
    localparam logic [IW-1:0]      LAST_IDX  = IW'(w_digit - 1);
    localparam logic [CW-1:0]      LAST_CNT  = CW'(scan_period - 1);
    localparam logic [CW-1:0]      BLANK_N   = CW'(blank_cycles);
    localparam logic [w_digit-1:0] ONE       = 1;
    localparam state_t             RST_STATE = blank_cycles > 0 ? BLANK : DRIVE;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic [w_value-1:0] r_staged, r_shown;
    logic               r_pending;
    logic               w_slot_end, w_frame_end;
    logic [7:0]         w_seg;

    seg7_digit_mux #(.w_digit(w_digit), .iw(IW)) u_mux (
        .i_value   (r_shown),
        .i_dp_mask (dp_mask),
        .i_idx     (r_idx),
        .i_lz_blank(lz_blank),
        .o_seg     (w_seg)
    );

    // The state tracks the slot counter so BLANK covers exactly the first blank_cycles of each slot.
    always_comb begin
        w_slot_end  = r_cnt == LAST_CNT;
        w_frame_end = w_slot_end && r_idx == LAST_IDX;
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = !w_slot_end ? r_idx : w_frame_end ? '0 : r_idx + 1'b1;
        w_state_nxt = w_cnt_nxt < BLANK_N ? BLANK : DRIVE;
    end

    // A strobe on the commit edge wins the staging slot and keeps pending set for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_staged   <= '0;
            r_shown    <= '0;
            r_pending  <= 1'b0;
            abcdefgh   <= '0;
            digit      <= '0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_staged   <= value_valid ? value : r_staged;
            r_shown    <= w_frame_end && r_pending ? r_staged : r_shown;
            r_pending  <= value_valid || (r_pending && !w_frame_end);
            abcdefgh   <= r_state == DRIVE ? w_seg : '0;
            digit      <= r_state == DRIVE ? ONE << r_idx : '0;
            frame_done <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_counter_display.sv
// tb_seg7_counter_display: frame-by-frame table of strobes and expected digit patterns,
// plus a hand-written mid-frame reset sequence.
module tb_seg7_counter_display;

    typedef struct {
        logic       lz;
        logic [3:0] dp;
        int         sk [3];
        logic [15:0] sv [3];
        logic [7:0] seg [4];
    } row_t;

    typedef struct packed {
        logic [3:0] digit;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, value_valid = 1'b0, lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit;
    logic [7:0]  abcdefgh;
    logic        frame_done;
    int          checks = 0, errors = 0;
    row_t        rows [10];
    exp_t        sb [$];

    always #5 clk = ~clk;

    seg7_counter_display #(
        .clk_mhz(50), .w_digit(4), .w_value(16), .scan_period(8), .blank_cycles(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .value_valid(value_valid),
        .lz_blank   (lz_blank),
        .dp_mask    (dp_mask),
        .abcdefgh   (abcdefgh),
        .digit      (digit),
        .frame_done (frame_done)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        value_valid = 1'b0;
    endtask

    task automatic check(input string name, input exp_t e);
        checks++;
        if (digit !== e.digit || abcdefgh !== e.seg || frame_done !== e.fd) begin
            errors++;
            $display("FAIL %s: got digit=%b seg=%h fd=%b, expected digit=%b seg=%h fd=%b",
                     name, digit, abcdefgh, frame_done, e.digit, e.seg, e.fd);
        end
    endtask

    task automatic set_row(input int r, input logic lz, input logic [3:0] dp,
                           input int k0, input logic [15:0] v0, input int k1, input logic [15:0] v1,
                           input int k2, input logic [15:0] v2,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
        rows[r].lz = lz;
        rows[r].dp = dp;
        rows[r].sk[0] = k0; rows[r].sv[0] = v0;
        rows[r].sk[1] = k1; rows[r].sv[1] = v1;
        rows[r].sk[2] = k2; rows[r].sv[2] = v2;
        rows[r].seg[0] = s0; rows[r].seg[1] = s1;
        rows[r].seg[2] = s2; rows[r].seg[3] = s3;
    endtask

    // Entered just after a frame boundary sample (state at slot 0, cycle 0); observes one full frame.
    task automatic run_row(input int r);
        exp_t e;
        lz_blank = rows[r].lz;
        dp_mask  = rows[r].dp;
        for (int k = 1; k <= 32; k++) begin
            int c, sl;
            c  = (k - 1) % 8;
            sl = (k - 1) / 8;
            e.digit = c < 2 ? 4'b0000 : 4'b0001 << sl;
            e.seg   = c < 2 ? 8'h00 : rows[r].seg[sl];
            e.fd    = k == 32;
            sb.push_back(e);
        end
        for (int k = 1; k <= 32; k++) begin
            for (int j = 0; j < 3; j++)
                if (rows[r].sk[j] == k) begin
                    value       = rows[r].sv[j];
                    value_valid = 1'b1;
                end
            tick();
            e = sb.pop_front();
            check($sformatf("row%0d_k%0d", r, k), e);
        end
    endtask

    initial begin
        exp_t z;
        z = '{4'b0000, 8'h00, 1'b0};
        //          r  lz    dp     k0  v0        k1  v1        k2  v2        d0     d1     d2     d3
        set_row(0, 1'b0, 4'h0,  1, 16'h12AF,  0, 16'h0000,  0, 16'h0000, 8'hFC, 8'hFC, 8'hFC, 8'hFC);
        set_row(1, 1'b0, 4'h0,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'h8E, 8'hEE, 8'hDA, 8'h60);
        set_row(2, 1'b0, 4'h0,  5, 16'h1111, 20, 16'h2222, 32, 16'h3333, 8'h8E, 8'hEE, 8'hDA, 8'h60);
        set_row(3, 1'b0, 4'h0,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'hDA, 8'hDA, 8'hDA, 8'hDA);
        set_row(4, 1'b0, 4'h0,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'hF2, 8'hF2, 8'hF2, 8'hF2);
        set_row(5, 1'b1, 4'h4,  3, 16'h0050,  0, 16'h0000,  0, 16'h0000, 8'hF2, 8'hF2, 8'hF3, 8'hF2);
        set_row(6, 1'b1, 4'h4,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'hFC, 8'hB6, 8'h01, 8'h00);
        set_row(7, 1'b0, 4'h0,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'hFC, 8'hB6, 8'hFC, 8'hFC);
        set_row(8, 1'b0, 4'h0,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'hFC, 8'hFC, 8'hFC, 8'hFC);
        set_row(9, 1'b0, 4'h0,  0, 16'h0000,  0, 16'h0000,  0, 16'h0000, 8'hFC, 8'hFC, 8'hFC, 8'hFC);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_%0d", i), z);
        end
        rst = 1'b0;
        for (int r = 0; r < 8; r++)
            run_row(r);

        // Mid-frame reset with 0xABCD pending, asserted while digit 2 is driving.
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                value       = 16'hABCD;
                value_valid = 1'b1;
            end
            tick();
        end
        check("pre_reset_digit2", '{4'b0100, 8'hFC, 1'b0});
        rst = 1'b1;
        tick();
        check("mid_reset_outputs", z);
        rst = 1'b0;
        run_row(8);
        run_row(9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
